// File: rtl/adder_rr_sched_pkg.sv
// Shared constants, the ID-width helper and the result record for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int W_DEF    = 8;
  localparam int NREQ_MAX = 4;

  // A requester index needs at least one bit, even when only two requesters exist.
  function automatic int idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Default-width view of one scheduled result; the top keeps a W-wide copy of this layout.
  typedef struct packed {
    logic                          carry;
    logic [W_DEF-1:0]              sum;
    logic [$clog2(NREQ_MAX)-1:0]   id;
  } result_t;

endpackage

// File: rtl/adder_rr_sched_rr_arbiter.sv
// Round-robin arbiter: combinational grant scanning from ptr_q, pointer register advances past each winner.
// Zero-cycle grant; grants nothing while en_i is low, pointer moves only on adv_i.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int  NREQ = 2,
  localparam int IDW  = idw(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o
);

  localparam logic [IDW:0]   NREQ_X = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW:0]   scan_sum;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    scan_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Wrap explicitly so non-power-of-two NREQ scans modulo NREQ.
      scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_sum >= NREQ_X) scan_sum = scan_sum - NREQ_X;
      cand = scan_sum[IDW-1:0];
      if (en_i && !found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        gnt_idx_o    = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = (gnt_idx_o == LAST) ? '0 : gnt_idx_o + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Shares one W+1-bit adder among NREQ valid/ready requesters; result lands in a one-entry register 1 cycle later.
// Grants only when the output register is empty or being popped; pop and load may share an edge.
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int  NREQ = 2,
  parameter int  W    = W_DEF,
  localparam int IDW  = idw(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_carry,
  output logic [IDW-1:0]    res_id
);

  if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("adder_rr_sched: NREQ out of range");
  end

  typedef struct packed {
    logic           carry;
    logic [W-1:0]   sum;
    logic [IDW-1:0] id;
  } res_t;

  logic            can_load;
  logic            xfer;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [W-1:0]    a_sel, b_sel;
  logic [W:0]      sum_full;
  logic            res_vld_q, res_vld_d;
  res_t            res_q, res_d;

  // Reset gates the enable so no grant escapes while rst_n is low.
  assign can_load  = rst_n && (!res_vld_q || res_ready);
  assign xfer      = |gnt;
  assign req_ready = gnt;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .en_i      (can_load),
    .adv_i     (xfer),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*W +: W];
        b_sel = req_b[i*W +: W];
      end
    end
  end

  assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

  always_comb begin
    res_vld_d = res_vld_q;
    res_d     = res_q;
    if (xfer) begin
      res_vld_d   = 1'b1;
      res_d.carry = sum_full[W];
      res_d.sum   = sum_full[W-1:0];
      res_d.id    = gnt_idx;
    end else if (res_ready) begin
      res_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
    end
  end

  assign res_valid = res_vld_q;
  assign res_sum   = res_q.sum;
  assign res_carry = res_q.carry;
  assign res_id    = res_q.id;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench: a 2-requester and a 4-requester scheduler share clock and reset.
module tb_adder_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [1:0]  v2, rdy2;
  logic [15:0] a2, b2;
  logic        rv2, rr2, c2;
  logic [7:0]  sum2;
  logic [0:0]  id2;

  logic [3:0]  v4, rdy4;
  logic [31:0] a4, b4;
  logic        rv4, rr4, c4;
  logic [7:0]  sum4;
  logic [1:0]  id4;

  int tests  = 0;
  int failed = 0;

  adder_rr_sched #(.NREQ(2), .W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
    .req_a(a2), .req_b(b2), .res_valid(rv2), .res_ready(rr2),
    .res_sum(sum2), .res_carry(c2), .res_id(id2)
  );

  adder_rr_sched #(.NREQ(4), .W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(rdy4),
    .req_a(a4), .req_b(b4), .res_valid(rv4), .res_ready(rr4),
    .res_sum(sum4), .res_carry(c4), .res_id(id4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic v, input logic [0:0] id,
                      input logic [7:0] s, input logic c);
    chk({tag, ".valid"}, 32'(rv2), 32'(v));
    chk({tag, ".id"},    32'(id2), 32'(id));
    chk({tag, ".sum"},   32'(sum2), 32'(s));
    chk({tag, ".carry"}, 32'(c2), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // req0: F0+20 = 0x110, req1: 05+07 = 0x0C
    a2 = {8'h05, 8'hF0};
    b2 = {8'h07, 8'h20};
    // req1: FF+01 = 0x100, req3: 7F+80 = 0x0FF
    a4 = {8'h7F, 8'h00, 8'hFF, 8'h00};
    b4 = {8'h80, 8'h00, 8'h01, 8'h00};

    // Reset with everything requesting and the consumer ready.
    rst_n = 1'b0; v2 = 2'b11; rr2 = 1'b1; v4 = 4'b1111; rr4 = 1'b1;
    #1;
    chk("rst.rdy2_pre", 32'(rdy2), 32'h0);
    chk("rst.rdy4_pre", 32'(rdy4), 32'h0);
    tick();
    chk("rst.rdy2_c1", 32'(rdy2), 32'h0);
    chk("rst.rdy4_c1", 32'(rdy4), 32'h0);
    chk2("rst.out_c1", 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("rst.rdy2_c2", 32'(rdy2), 32'h0);
    chk2("rst.out_c2", 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst.rv4", 32'(rv4), 32'h0);
    chk("rst.sum4", 32'(sum4), 32'h0);
    chk("rst.id4", 32'(id4), 32'h0);

    // Release: first grant to requester 0, then strict alternation.
    rst_n = 1'b1; v4 = 4'b0000;
    #1;
    chk("cont.g0", 32'(rdy2), 32'h1);
    tick();
    chk2("cont.r0", 1'b1, 1'b0, 8'h10, 1'b1);
    chk("cont.g1", 32'(rdy2), 32'h2);
    tick();
    chk2("cont.r1", 1'b1, 1'b1, 8'h0C, 1'b0);
    chk("cont.g2", 32'(rdy2), 32'h1);
    tick();
    chk2("cont.r2", 1'b1, 1'b0, 8'h10, 1'b1);
    chk("cont.g3", 32'(rdy2), 32'h2);
    tick();
    chk2("cont.r3", 1'b1, 1'b1, 8'h0C, 1'b0);

    // Single add from requester 0; pointer is back at 0.
    v2 = 2'b01;
    #1;
    chk("single.g", 32'(rdy2), 32'h1);
    tick();
    chk2("single.r", 1'b1, 1'b0, 8'h10, 1'b1);
    v2 = 2'b00;
    #1;
    chk("single.idle_rdy", 32'(rdy2), 32'h0);
    tick();
    chk2("single.drain", 1'b0, 1'b0, 8'h10, 1'b1);

    // Backpressure: pointer is 1, so requester 1 wins first.
    v2 = 2'b11; rr2 = 1'b0;
    #1;
    chk("bp.g", 32'(rdy2), 32'h2);
    tick();
    chk2("bp.load", 1'b1, 1'b1, 8'h0C, 1'b0);
    chk("bp.rdy0", 32'(rdy2), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.rdy_hold", 32'(rdy2), 32'h0);
      chk2("bp.hold", 1'b1, 1'b1, 8'h0C, 1'b0);
    end
    rr2 = 1'b1;
    #1;
    chk("bp.pop_grant", 32'(rdy2), 32'h1);
    tick();
    chk2("bp.next", 1'b1, 1'b0, 8'h10, 1'b1);

    // Reset mid-operation: result held, pointer at 1.
    rr2 = 1'b0; rst_n = 1'b0;
    #1;
    chk("mid.rdy", 32'(rdy2), 32'h0);
    tick();
    chk2("mid.cleared", 1'b0, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b1; rr2 = 1'b1;
    #1;
    chk("mid.lowest", 32'(rdy2), 32'h1);
    tick();
    chk2("mid.after", 1'b1, 1'b0, 8'h10, 1'b1);
    v2 = 2'b00;

    // Skip-over on the 4-requester instance: only 1 and 3 request.
    v4 = 4'b1010;
    #1;
    chk("skip.g0", 32'(rdy4), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("skip.rv", 32'(rv4), 32'h1);
      if (i % 2 == 0) begin
        chk("skip.id1", 32'(id4), 32'h1);
        chk("skip.sum1", 32'(sum4), 32'h00);
        chk("skip.c1", 32'(c4), 32'h1);
        chk("skip.g3", 32'(rdy4), 32'h8);
      end else begin
        chk("skip.id3", 32'(id4), 32'h3);
        chk("skip.sum3", 32'(sum4), 32'hFF);
        chk("skip.c3", 32'(c4), 32'h0);
        chk("skip.g1", 32'(rdy4), 32'h2);
      end
    end
    tick();
    chk("skip.id_last", 32'(id4), 32'h3);
    v4 = 4'b0000;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
